// File: rtl/tx_pkg.sv
// Shared constants and FSM encoding for the transmit buffer datapath.
// Reused by the buffer itself and by the blocks that read it.
package tx_pkg;

    localparam int TX_DATA_WIDTH = 32;
    localparam int TX_ADDR_WIDTH = 4;
    localparam int TX_MEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tx_skid_fifo.sv
// Two-entry FIFO that absorbs the buffer read latency under backpressure.
// Simultaneous push and pop are both honoured; clear empties it in one edge.
module tx_skid_fifo
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] slot [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign pop_ok  = pop && (occ != 2'd0);
    assign push_ok = push && ((occ != 2'd2) || pop_ok);
    assign head    = slot[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else if (clear) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/tx_mem_reader.sv
// Walks a window of the transmit buffer and streams the words out on a
// valid/ready interface, hiding the buffer's one-cycle read latency.
module tx_mem_reader
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TX_ADDR_WIDTH,
    parameter int MEM_DEPTH  = TX_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH + 1)'(1);

    tx_state_t             state;
    tx_state_t             state_nx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   issue_left;
    logic [ADDR_WIDTH:0]   send_left;
    logic                  inflight;
    logic [1:0]            occ;
    logic [2:0]            pending;
    logic                  pop;
    logic                  issue;
    logic                  accept;
    logic                  last_pop;
    logic                  busy_nx;
    logic                  done_nx;

    assign pop      = tx_valid && tx_ready;
    assign last_pop = pop && (send_left == ONE);
    assign accept   = (state == IDLE) && start && (word_count != '0) && !abort;

    // Reads already owed to the FIFO after this cycle's pop; keep it <= 2.
    assign pending  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue    = (state == RUN) && (pending <= 3'd1);

    assign mem_rd_req = issue;
    assign mem_addr   = rd_addr;
    assign tx_valid   = (occ != 2'd0);
    assign tx_last    = tx_valid && (send_left == ONE);

    tx_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort),
        .push      (inflight),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (tx_data),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (issue && (issue_left == ONE)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
        end
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr    <= '0;
            issue_left <= '0;
            send_left  <= '0;
            inflight   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            inflight <= issue && !abort;
            busy     <= busy_nx;
            done     <= done_nx;
            if (accept) begin
                rd_addr    <= start_addr;
                issue_left <= word_count;
                send_left  <= word_count;
            end else begin
                if (issue) begin
                    rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                    issue_left <= issue_left - ONE;
                end
                if (pop) begin
                    send_left <= send_left - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_mem_reader.sv
// Directed bench for tx_mem_reader: table of transfers plus abort,
// reset and ignored-start sequences against a 16x32 buffer model.
module tb_tx_mem_reader;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   wc;
        int            mode;
        bit            dup;
        int            first_valid;
        int            done_win;
        logic [DW-1:0] last_word;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          abort;
    logic          mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_req) mem_rd_data <= mem[mem_addr];
    end

    tx_mem_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .abort       (abort),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int w);
        logic [31:0] wv;
        wv = w;
        case (mode)
            1:       return wv[0];
            2:       return (w >= 11);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_xfer(input vec_t v);
        int            hs;
        int            reads;
        int            reads10;
        int            fv;
        int            dw;
        int            max_out;
        logic [DW-1:0] prev_d;
        logic          prev_last;
        logic          prev_stall;
        logic [AW-1:0] a;
        hs = 0; reads = 0; reads10 = 0; fv = -1; dw = -1;
        max_out = 0; prev_stall = 1'b0; prev_d = '0; prev_last = 1'b0;
        for (int w = 0; w < 80 && dw < 0; w++) begin
            @(negedge clk);
            start    = (w == 0) || (v.dup && w == 2);
            tx_ready = ready_for(v.mode, w);
            if (w == 0) begin
                start_addr = v.sa;
                word_count = v.wc;
            end else begin
                start_addr = 4'd7;
                word_count = 5'd5;
            end
            #1;
            if (w == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (mem_rd_req) reads++;
            if (w == 10) reads10 = reads;
            if (tx_valid && fv < 0) fv = w;
            if (prev_stall) begin
                chk("hold_data", tx_data, prev_d);
                chk("hold_last", {31'd0, tx_last}, {31'd0, prev_last});
            end
            if (tx_valid && tx_ready) begin
                a = v.sa + AW'(hs);
                chk("word", tx_data, 32'hA000_0000 + {28'd0, a});
                chk("last_flag", {31'd0, tx_last}, {31'd0, hs == v.wc - 1});
                if (hs == v.wc - 1) chk("last_word", tx_data, v.last_word);
                hs++;
            end
            if (reads - hs > max_out) max_out = reads - hs;
            prev_stall = tx_valid && !tx_ready;
            prev_d     = tx_data;
            prev_last  = tx_last;
            if (done) begin
                dw = w;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        start = 1'b0;
        chk("handshakes", hs, {27'd0, v.wc});
        chk("reads", reads, {27'd0, v.wc});
        chk("first_valid_win", fv, v.first_valid);
        chk("done_win", dw, v.done_win);
        chk("outstanding_le2", {31'd0, max_out <= 2}, 32'd1);
        if (v.mode == 2) chk("reads_while_stalled", reads10, 32'd2);
        @(negedge clk);
        #1;
        chk("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            {24'd0, mem_addr, mem_rd_req, tx_valid, tx_last, busy, done},
            32'd0);
        chk({tag, "_tx_data"}, tx_data, 32'd0);
    endtask

    vec_t tbl [6];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
        tbl[0] = '{4'd2,  5'd3,  0, 1'b1, 3, 6,  32'hA000_0004};
        tbl[1] = '{4'd14, 5'd4,  0, 1'b0, 3, 7,  32'hA000_0001};
        tbl[2] = '{4'd5,  5'd16, 1, 1'b0, 3, 34, 32'hA000_0004};
        tbl[3] = '{4'd8,  5'd5,  2, 1'b0, 3, 16, 32'hA000_000C};
        tbl[4] = '{4'd15, 5'd1,  0, 1'b0, 3, 4,  32'hA000_000F};
        tbl[5] = '{4'd9,  5'd16, 0, 1'b0, 3, 19, 32'hA000_0008};

        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
        start_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

        // start with zero length is dropped
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; word_count = 5'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_len_busy", {30'd0, busy, mem_rd_req}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("zero_len_later", {29'd0, busy, done, tx_valid}, 32'd0);

        // abort and start together: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1; start_addr = 4'd1; word_count = 5'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abort_start_busy", {30'd0, busy, mem_rd_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_start_valid", {31'd0, tx_valid}, 32'd0);

        // abort after the second handshake of a 6-word transfer
        @(negedge clk);
        start = 1'b1; start_addr = 4'd10; word_count = 5'd6; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_hs2_word", tx_data, 32'hA000_000B);
        @(negedge clk);
        abort = 1'b1; tx_ready = 1'b0;
        #1;
        chk("abort_pre_valid", {31'd0, tx_valid}, 32'd1);
        @(negedge clk);
        abort = 1'b0; tx_ready = 1'b1;
        #1;
        chk("abort_post", {28'd0, tx_valid, busy, done, mem_rd_req}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", {30'd0, done, tx_valid}, 32'd0);
        run_xfer('{4'd0, 5'd1, 0, 1'b0, 3, 4, 32'hA000_0000});

        // reset in the middle of a transfer
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; word_count = 5'd8; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        run_xfer('{4'd2, 5'd3, 0, 1'b0, 3, 6, 32'hA000_0004});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_mem_reader.md
Name: tx_mem_reader

Overview:
- Downstream consumer of the 16x32 transmit buffer memory.
- On a start command, walks a programmed window of buffer addresses, issues single-cycle reads and absorbs the memory's 1-cycle registered read latency.
- Delivers each word on a valid/ready stream to the transmit serializer, with full backpressure support and no word loss or duplication.
- Sits between the APB-written transmit buffer and the line transmitter.

Parameters:
- DATA_WIDTH, 32, width of memory words and stream data.
- ADDR_WIDTH, 4, buffer address width (log2 of MEM_DEPTH).
- MEM_DEPTH, 16, number of buffer entries; address wrap modulus.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle command pulse; honoured only in IDLE.
- start_addr  input  ADDR_WIDTH  first buffer address, sampled with start.
- word_count  input  ADDR_WIDTH+1  number of words to send, 1..MEM_DEPTH, sampled with start.
- abort  input  1  synchronous cancel of the current transfer.
- mem_rd_req  output  1  read strobe; the buffer's wr must be low while this is high.
- mem_addr  output  ADDR_WIDTH  buffer read address.
- mem_rd_data  input  DATA_WIDTH  buffer data_out; valid one edge after the request edge.
- tx_data  output  DATA_WIDTH  stream word.
- tx_valid  output  1  stream valid.
- tx_ready  input  1  stream ready from the serializer.
- tx_last  output  1  marks the final word of the transfer; qualified by tx_valid.
- busy  output  1  high from the accepted start until done or abort.
- done  output  1  one-cycle pulse after the final word handshake.

Behaviour:
- Reset: every output is 0 (mem_rd_req, mem_addr, tx_data, tx_valid, tx_last, busy, done). State is IDLE, FIFO is empty, in-flight flag is clear.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with word_count != 0. Loads rd_addr=start_addr, issue_left=word_count, send_left=word_count. busy=1 from the next cycle.
  - start with word_count == 0 is ignored: no busy, no done.
  - start while not IDLE is ignored.
  - RUN -> DRAIN when the last read is issued (issue_left reaches 0).
  - DRAIN -> IDLE on the handshake of the final word. done=1 for exactly the next cycle; busy=0 in that same cycle.
- Read issue:
  - Combinational rule: mem_rd_req = (state==RUN) && (fifo_occ + inflight - pop) <= 1, where pop = tx_valid && tx_ready.
  - mem_addr = rd_addr.
  - On issue: rd_addr increments modulo MEM_DEPTH (15 -> 0 wrap), issue_left decrements, inflight is set for the next cycle.
- Return path: when inflight==1, mem_rd_data is written into a 2-entry FIFO at that edge. Captured data is never discarded except on abort or reset.
- Latency: start sampled at edge E0 -> mem_rd_req high during E0..E1 -> memory registers data at E1 -> FIFO captures at E2 -> tx_valid high after E2.
- Throughput: with tx_ready held high, one word per cycle sustained.
- Stream rules:
  - tx_valid = FIFO not empty; tx_data = FIFO head.
  - tx_data and tx_last stay stable while tx_valid && !tx_ready.
  - tx_last = tx_valid && send_left==1.
  - send_left decrements on each handshake.
- FIFO bound: occupancy + inflight never exceeds 2, so the FIFO never overflows. A push and a pop in the same cycle are both honoured.
- Abort, any state: at the next edge the block returns to IDLE, clears the FIFO and inflight, and drives tx_valid=0 and busy=0. No done pulse.
  - abort together with start in IDLE: abort wins; the start is dropped.
- Reset mid-transfer: same effect as abort, with all outputs cleared to their reset values.
- word_count==MEM_DEPTH starting at any address reads every entry exactly once, with wrap.

Decomposition:
- Shared package tx_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - default DATA_WIDTH/ADDR_WIDTH/MEM_DEPTH constants reused by the transmit buffer.
- One sub-module, tx_skid_fifo: 2-entry synchronous FIFO with push, pop, occupancy and head data, reset to empty.
- The read issue and stream control stay in tx_mem_reader.

Test Plan:
- Memory preloaded mem[i]=32'hA000_0000+i; start_addr=2, word_count=3, tx_ready=1 -> tx_data 0xA0000002, 0xA0000003, 0xA0000004 on consecutive cycles; tx_valid first rises 2 edges after the start edge; tx_last on the 3rd word; done one cycle later.
- start_addr=14, word_count=4 -> addresses 14, 15, 0, 1; data 0xA000000E, 0xA000000F, 0xA0000000, 0xA0000001.
- word_count=16, tx_ready toggling 1/0 each cycle -> all 16 words delivered in order with no duplicates; FIFO occupancy never exceeds 2; tx_data held stable while not ready.
- tx_ready=0 for 10 cycles after start -> exactly 2 reads issued, then mem_rd_req stays low until ready returns; remaining words follow in order.
- abort asserted after the 2nd handshake of a 6-word transfer -> next cycle tx_valid=0, busy=0, no done; a new start (addr 0, count 1) then delivers 0xA0000000.
- start with word_count=0, and start while busy -> both ignored; busy/done unaffected. Reset mid-transfer -> all outputs 0 next cycle.
